mem_bus_router: RTL and testbench
=================================

Name: mem_bus_router

Overview:
- Parametrised 1-to-N memory bus router. It is the successor to the fixed three-port bus arbiter.
- Sits between one core bus port (imem or dmem) and NUM_SLAVES targets (RAM, console, peripherals).
- Adds configurable base/mask address decode with lowest-index priority.
- Adds an error response for unmapped addresses, a per-transaction timeout, and a saturating error counter.

Parameters:
- NUM_SLAVES, 4, number of downstream ports (1..16).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- SLAVE_BASE, {0x20000000,0x10000000,0x00000000,0x000FFFFC}, flattened NUM_SLAVES*ADDR_WIDTH; slice i is the base of port i.
- SLAVE_MASK, {0xFFFF0000,0xFFFF0000,0xFFF00000,0xFFFFFFFC}, flattened; port i matches when (addr & mask_i) == (base_i & mask_i).
- TIMEOUT_CYCLES, 255, ACTIVE cycles without slave ready before an error; 0 disables the timeout.
- ERR_RDATA, 0xDEADBEEF, read data returned on an error response.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- s_valid_i  in  1  request valid from core
- s_ready_o  out  1  transaction complete; rdata valid this cycle
- s_addr_i  in  ADDR_WIDTH  request address
- s_wdata_i  in  DATA_WIDTH  write data
- s_we_i  in  DATA_WIDTH/8  byte write enables; all zero means read
- s_rdata_o  out  DATA_WIDTH  read data
- s_err_o  out  1  qualifies s_ready_o as an error completion
- m_valid_o  out  NUM_SLAVES  one-hot request valid
- m_ready_i  in  NUM_SLAVES  per-slave completion
- m_addr_o  out  NUM_SLAVES*ADDR_WIDTH  per-slave address (broadcast copy of s_addr_i)
- m_wdata_o  out  NUM_SLAVES*DATA_WIDTH  per-slave write data (broadcast)
- m_we_o  out  NUM_SLAVES*DATA_WIDTH/8  per-slave byte enables; zero for unselected ports
- m_rdata_i  in  NUM_SLAVES*DATA_WIDTH  per-slave read data
- err_cnt_o  out  8  saturating count of error completions

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, m_valid_o=0, s_ready_o=0, s_err_o=0, s_rdata_o=0, err_cnt_o=0, timeout counter=0.
  - Takes effect immediately, including mid-transaction; an in-flight slave transaction is abandoned.
- Handshake:
  - Core holds s_valid_i/addr/wdata/we stable until s_ready_o is seen high for one cycle.
  - s_ready_o is a single-cycle pulse.
- IDLE:
  - s_valid_i=1 starts a decode. Lowest matching index wins.
  - Match: register the index; next state is ACTIVE.
  - No match: next state is ERR.
  - s_ready_o=0.
- ACTIVE:
  - m_valid_o[idx]=1, driven from registered state, so it asserts 1 cycle after s_valid_i rises. All other m_valid_o bits are 0.
  - s_ready_o = m_ready_i[idx] (combinational). s_rdata_o = m_rdata_i slice idx while ready is high, else 0.
  - m_ready_i=1 -> next state IDLE; timeout counter cleared.
  - Ready on non-selected ports is ignored.
  - Timeout: counter increments on every ACTIVE cycle without ready. When it reaches TIMEOUT_CYCLES -> next state ERR and m_valid_o drops.
  - If ready arrives on the same cycle the counter hits the limit, ready wins (normal completion).
  - s_valid_i deasserted in ACTIVE (protocol abort): next state IDLE, no s_ready_o, no error counted.
- ERR (one cycle):
  - s_ready_o=1, s_err_o=1, s_rdata_o=ERR_RDATA, m_valid_o=0.
  - err_cnt_o increments, saturating at 255.
  - Next state IDLE. A slave ready arriving in ERR is ignored.
- Timing:
  - Minimum latency is 2 cycles (decode register + same-cycle slave ready).
  - The cycle after any completion is always IDLE, so back-to-back transactions take (2 + slave latency) cycles each.
- Outputs:
  - m_addr_o and m_wdata_o broadcast s_addr_i/s_wdata_i unregistered to every slice.
  - m_we_o slice i = s_we_i when idx==i and state is ACTIVE, else 0.

Decomposition:
- Shared defines file:
  - State encodings ROUTER_IDLE=2'd0, ROUTER_ACTIVE=2'd1, ROUTER_ERR=2'd2.
  - Default ERR_RDATA.
  - Reuse RISCV_ADDR_WIDTH/RISCV_WORD_WIDTH as the defaults for ADDR_WIDTH/DATA_WIDTH.
- Sub-module mem_bus_addr_decoder:
  - Purely combinational priority base/mask match.
  - Outputs hit and index ($clog2(NUM_SLAVES) bits).
  - Reusable by the top-level console and peripheral decode.

Test Plan:
- Read 0x00000100, slave1 ready 2 cycles after m_valid_o[1] with rdata 0x12345678 -> m_valid_o=4'b0010; s_ready_o pulses once with s_rdata_o=0x12345678, 3 cycles after s_valid_i; s_err_o=0.
- Write 0x000FFFFC, we=4'b1000, wdata=0x41000000 -> priority selects port 0 over overlapping port 1; m_we_o slice0=4'b1000, all other slices 0.
- Read 0x30000000 (unmapped) -> no m_valid_o; 1 cycle later s_ready_o=1, s_err_o=1, s_rdata_o=0xDEADBEEF; err_cnt_o 0->1.
- TIMEOUT_CYCLES=4, slave2 never ready on access to 0x10000000 -> m_valid_o[2] high for exactly 4 cycles, then ERR completion with 0xDEADBEEF; a late m_ready_i[2] is ignored.
- 300 unmapped accesses back-to-back -> err_cnt_o saturates at 255.
- rst_n low while ACTIVE on port 3 -> m_valid_o=0 and s_ready_o=0 immediately; after release, the first new request decodes normally.

Source files
------------

// File: rtl/mem_bus_router_pkg.sv
// Shared definitions for the memory bus router and its address decoder.
package mem_bus_router_pkg;

  localparam int RISCV_ADDR_WIDTH = 32;
  localparam int RISCV_WORD_WIDTH = 32;

  // Read data returned with an error completion, easy to spot in a dump.
  localparam logic [31:0] ROUTER_ERR_RDATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ROUTER_IDLE   = 2'd0,
    ROUTER_ACTIVE = 2'd1,
    ROUTER_ERR    = 2'd2
  } router_state_e;

  // Width of a port index; a single-port router still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_addr_decoder.sv
// Combinational base/mask address decoder; the lowest matching port index wins.
module mem_bus_addr_decoder
  import mem_bus_router_pkg::*;
#(
  parameter int                               NUM_SLAVES = 4,
  parameter int                               ADDR_WIDTH = RISCV_ADDR_WIDTH,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  localparam int                              IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [IDX_W-1:0]      index
);

  // Scan from the highest index down so a lower matching index overrides.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit   = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_bus_router.sv
// 1-to-N memory bus router: base/mask decode, error completion for unmapped
// addresses, per-transaction timeout and a saturating error counter.
//
// state  | meaning
// IDLE   | waiting for s_valid_i; decode the address
// ACTIVE | request presented to the selected port, waiting for its ready
// ERR    | one-cycle error completion (unmapped address or timeout)
module mem_bus_router
  import mem_bus_router_pkg::*;
#(
  parameter int                               NUM_SLAVES     = 4,
  parameter int                               ADDR_WIDTH     = RISCV_ADDR_WIDTH,
  parameter int                               DATA_WIDTH     = RISCV_WORD_WIDTH,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE     = {32'h20000000, 32'h10000000,
                                                                32'h00000000, 32'h000FFFFC},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK     = {32'hFFFF0000, 32'hFFFF0000,
                                                                32'hFFF00000, 32'hFFFFFFFC},
  parameter int                               TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0]            ERR_RDATA      = DATA_WIDTH'(ROUTER_ERR_RDATA),
  localparam int                              BE_W           = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_valid_i,
  output logic                             s_ready_o,
  input  logic [ADDR_WIDTH-1:0]            s_addr_i,
  input  logic [DATA_WIDTH-1:0]            s_wdata_i,
  input  logic [BE_W-1:0]                  s_we_i,
  output logic [DATA_WIDTH-1:0]            s_rdata_o,
  output logic                             s_err_o,
  output logic [NUM_SLAVES-1:0]            m_valid_o,
  input  logic [NUM_SLAVES-1:0]            m_ready_i,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_addr_o,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] m_wdata_o,
  output logic [NUM_SLAVES*BE_W-1:0]       m_we_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_rdata_i,
  output logic [7:0]                       err_cnt_o
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  // The counter only ever needs to hold TIMEOUT_CYCLES-1 before the limit fires.
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  router_state_e    state;
  logic [IDX_W-1:0] idx;
  logic [TO_W-1:0]  to_cnt;
  logic [7:0]       err_cnt;
  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             sel_ready;

  mem_bus_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .addr  (s_addr_i),
    .hit   (dec_hit),
    .index (dec_idx)
  );

  // Ready from the selected port only; other ports' ready is ignored.
  always_comb begin
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == IDX_W'(i)) sel_ready = m_ready_i[i];
    end
  end

  // Router FSM with timeout counter and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ROUTER_IDLE;
      idx     <= '0;
      to_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        ROUTER_IDLE: begin
          to_cnt <= '0;
          if (s_valid_i) begin
            if (dec_hit) begin
              idx   <= dec_idx;
              state <= ROUTER_ACTIVE;
            end else begin
              state <= ROUTER_ERR;
            end
          end
        end
        ROUTER_ACTIVE: begin
          // Abort first, then ready, so ready wins over a timeout on the same cycle.
          if (!s_valid_i || sel_ready) begin
            state  <= ROUTER_IDLE;
            to_cnt <= '0;
          end else if (TO_EN && (to_cnt == TO_LIMIT)) begin
            state  <= ROUTER_ERR;
            to_cnt <= '0;
          end else if (TO_EN) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ROUTER_ERR: begin
          state <= ROUTER_IDLE;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
        default: state <= ROUTER_IDLE;
      endcase
    end
  end

  // Core-side response and per-port strobes, all decoded from registered state.
  always_comb begin
    s_ready_o = 1'b0;
    s_err_o   = 1'b0;
    s_rdata_o = '0;
    m_valid_o = '0;
    m_we_o    = '0;
    case (state)
      ROUTER_ACTIVE: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (idx == IDX_W'(i)) begin
            m_valid_o[i]             = 1'b1;
            m_we_o[i*BE_W +: BE_W]   = s_we_i;
            if (s_valid_i && m_ready_i[i]) begin
              s_ready_o = 1'b1;
              s_rdata_o = m_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
      ROUTER_ERR: begin
        s_ready_o = 1'b1;
        s_err_o   = 1'b1;
        s_rdata_o = ERR_RDATA;
      end
      default: ;
    endcase
  end

  assign m_addr_o  = {NUM_SLAVES{s_addr_i}};
  assign m_wdata_o = {NUM_SLAVES{s_wdata_i}};
  assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_mem_bus_router.sv
// Self-checking bench for mem_bus_router (4 ports, timeout of 4 cycles).
module tb_mem_bus_router;

  localparam int N  = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_addr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_we;
  logic [31:0]   s_rdata;
  logic          s_err;
  logic [3:0]    m_valid;
  logic [3:0]    m_ready;
  logic [127:0]  m_addr;
  logic [127:0]  m_wdata;
  logic [15:0]   m_we;
  logic [127:0]  m_rdata;
  logic [7:0]    err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int err_model = 0;

  // Address map as the bench understands it: port i = base/mask pair i.
  logic [31:0] map_base [N] = '{32'h000FFFFC, 32'h00000000, 32'h10000000, 32'h20000000};
  logic [31:0] map_mask [N] = '{32'hFFFFFFFC, 32'hFFF00000, 32'hFFFF0000, 32'hFFFF0000};

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    int          lat;
    int          exp_port;
  } vec_t;

  vec_t vecs [10];

  mem_bus_router #(
    .NUM_SLAVES     (N),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .SLAVE_BASE     ({32'h20000000, 32'h10000000, 32'h00000000, 32'h000FFFFC}),
    .SLAVE_MASK     ({32'hFFFF0000, 32'hFFFF0000, 32'hFFF00000, 32'hFFFFFFFC}),
    .TIMEOUT_CYCLES (TO),
    .ERR_RDATA      (32'hDEADBEEF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .s_addr_i  (s_addr),
    .s_wdata_i (s_wdata),
    .s_we_i    (s_we),
    .s_rdata_o (s_rdata),
    .s_err_o   (s_err),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_addr_o  (m_addr),
    .m_wdata_o (m_wdata),
    .m_we_o    (m_we),
    .m_rdata_i (m_rdata),
    .err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_port(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & map_mask[i]) == (map_base[i] & map_mask[i])) return i;
    return -1;
  endfunction

  // One transaction, starting just after a rising edge. lat = cycles from
  // m_valid rising to the selected slave's ready (>= TO means it times out).
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata,
                         input int lat, input int exp_port, input string name);
    int          done_c;
    int          act_last;
    bit          exp_e;
    logic [3:0]  exp_mv;
    logic [3:0]  rdy;
    logic [15:0] exp_we;
    logic [31:0] exp_rd;
    if (exp_port < 0) begin
      done_c = 1; act_last = 0; exp_e = 1'b1;
    end else if (lat < TO) begin
      done_c = 1 + lat; act_last = 1 + lat; exp_e = 1'b0;
    end else begin
      done_c = TO + 1; act_last = TO; exp_e = 1'b1;
    end
    s_valid = 1'b1; s_addr = addr; s_we = we; s_wdata = wdata;
    for (int c = 0; c <= done_c; c++) begin
      rdy = 4'($urandom);
      if (exp_port >= 0) rdy[exp_port] = (c == 1 + lat);
      m_ready = rdy;
      m_rdata = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      exp_mv = (exp_port >= 0 && c >= 1 && c <= act_last) ? (4'b0001 << exp_port) : 4'b0000;
      exp_we = '0;
      if (exp_mv != 4'b0000) exp_we[exp_port*4 +: 4] = we;
      check({name, " m_valid"}, 128'(m_valid), 128'(exp_mv));
      check({name, " m_we"}, 128'(m_we), 128'(exp_we));
      check({name, " s_ready"}, 128'(s_ready), 128'(c == done_c));
      if (c == done_c) begin
        exp_rd = exp_e ? 32'hDEADBEEF : m_rdata[exp_port*32 +: 32];
        check({name, " s_err"}, 128'(s_err), 128'(exp_e));
        check({name, " s_rdata"}, 128'(s_rdata), 128'(exp_rd));
      end else begin
        check({name, " s_err idle"}, 128'(s_err), 128'(0));
        check({name, " s_rdata idle"}, 128'(s_rdata), 128'(0));
      end
      if (c == 0) begin
        check({name, " m_addr"}, m_addr, {4{addr}});
        check({name, " m_wdata"}, m_wdata, {4{wdata}});
      end
      @(posedge clk); #1;
    end
    if (exp_e && err_model < 255) err_model++;
    s_valid = 1'b0; m_ready = '0;
    check({name, " err_cnt"}, 128'(err_cnt), 128'(err_model));
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    bit          timed_out;

    vecs[0] = '{32'h00000100, 4'b0000, 32'h0,        2, 1};
    vecs[1] = '{32'h000FFFFC, 4'b1000, 32'h41000000, 0, 0};
    vecs[2] = '{32'h30000000, 4'b0000, 32'h0,        1, -1};
    vecs[3] = '{32'h10000000, 4'b0000, 32'h0,        4, 2};
    vecs[4] = '{32'h20001234, 4'b0000, 32'h0,        1, 3};
    vecs[5] = '{32'h000FFFF8, 4'b0000, 32'h0,        0, 1};
    vecs[6] = '{32'h000FFFFF, 4'b0001, 32'h000000AA, 1, 0};
    vecs[7] = '{32'h1000FFFF, 4'b0000, 32'h0,        3, 2};
    vecs[8] = '{32'h10010000, 4'b1111, 32'h55555555, 0, -1};
    vecs[9] = '{32'h2000FFFC, 4'b0011, 32'h0000BEEF, 0, 3};

    rst_n = 1'b0; s_valid = 1'b0; s_addr = '0; s_wdata = '0; s_we = '0;
    m_ready = '0; m_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset m_valid", 128'(m_valid), 128'(0));
    check("reset s_ready", 128'(s_ready), 128'(0));
    check("reset s_err", 128'(s_err), 128'(0));
    check("reset s_rdata", 128'(s_rdata), 128'(0));
    check("reset err_cnt", 128'(err_cnt), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_txn(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].lat, vecs[i].exp_port,
              $sformatf("vec%0d", i));

    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 4);
      if (sel < 4) a = map_base[sel] | ($urandom & ~map_mask[sel]);
      else         a = $urandom;
      run_txn(a, 4'($urandom), $urandom, $urandom_range(0, 5), ref_port(a),
              $sformatf("rnd%0d", i));
    end

    // Protocol abort: s_valid drops while ACTIVE, no completion, no error.
    s_valid = 1'b1; s_addr = 32'h20000040; s_we = '0; m_ready = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort m_valid active", 128'(m_valid), 128'(4'b1000));
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("abort no s_ready", 128'(s_ready), 128'(0));
    @(posedge clk); #1;
    check("abort m_valid idle", 128'(m_valid), 128'(0));
    check("abort err_cnt", 128'(err_cnt), 128'(err_model));

    // Back-to-back unmapped accesses drive the error counter into saturation.
    for (int i = 0; i < 300; i++)
      run_txn(32'h30000000 | (i << 2), 4'b0000, 32'h0, 0, -1, "sat");
    check("sat err_cnt 255", 128'(err_cnt), 128'(255));

    // Asynchronous reset in the middle of an ACTIVE transaction on port 3.
    s_valid = 1'b1; s_addr = 32'h20000010; m_ready = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst mid m_valid before", 128'(m_valid), 128'(4'b1000));
    #2;
    m_ready = 4'b1000;
    rst_n = 1'b0;
    #1;
    check("rst mid m_valid", 128'(m_valid), 128'(0));
    check("rst mid s_ready", 128'(s_ready), 128'(0));
    check("rst mid err_cnt", 128'(err_cnt), 128'(0));
    m_ready = '0; s_valid = 1'b0;
    err_model = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn(32'h00000200, 4'b0000, 32'h0, 1, 1, "post_rst");
    run_txn(32'h20000010, 4'b0110, 32'h12345678, 0, 3, "post_rst2");

    // Bounded wait on the DUT staying idle after the last completion.
    timed_out = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_valid == 4'b0000 && !s_ready) begin
        timed_out = 1'b0;
        break;
      end
    end
    check("final idle", 128'(timed_out), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
